// File: rtl/bus_mem_slave.sv
// Memory-backed bus slave: decodes its address window, inserts WAIT_CYCLES wait states,
// then performs the access and pulses ready. Define BUS_MEM_SLAVE_ERR_EN to add the err output.
module bus_mem_slave #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [3:0]  BASE_NIBBLE = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              ready,
  output logic [DATA_W-1:0] read_data,
`ifdef BUS_MEM_SLAVE_ERR_EN
  output logic              err,
`endif
  output logic              busy
);

  localparam int unsigned IdxW    = $clog2(MEM_DEPTH);
  localparam logic [3:0]  CntInit = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_q, wr_q, oow_q;

  logic              sel, oow_in, capture, access;
  logic [IdxW-1:0]   acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_rd, acc_wr, acc_oow;
  logic              mem_we, mem_re;
  logic              unused_addr;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  assign sel         = valid && (addr[15:12] == BASE_NIBBLE);
  assign capture     = (state_q == StIdle) && sel;
  assign unused_addr = ^addr;

`ifdef BUS_MEM_SLAVE_ERR_EN
  assign oow_in = ({1'b0, addr[11:0]} >= 13'(MEM_DEPTH));
`else
  assign oow_in = 1'b0;
`endif

  // With zero wait states the access happens on the accept edge, straight from the inputs.
  assign access = ((state_q == StIdle) && sel && (WAIT_CYCLES == 0)) ||
                  ((state_q == StWait) && (cnt_q == 4'd0));

  always_comb begin
    if (state_q == StIdle) begin
      acc_idx   = addr[IdxW-1:0];
      acc_wdata = write_data;
      acc_rd    = read;
      acc_wr    = write;
      acc_oow   = oow_in;
    end else begin
      acc_idx   = idx_q;
      acc_wdata = wdata_q;
      acc_rd    = rd_q;
      acc_wr    = wr_q;
      acc_oow   = oow_q;
    end
  end

  assign mem_we = access && acc_wr && !acc_rd && !acc_oow && !rst;
  assign mem_re = access && acc_rd && !acc_wr && !acc_oow;

  // State register and captured request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      oow_q     <= 1'b0;
      read_data <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        idx_q   <= addr[IdxW-1:0];
        wdata_q <= write_data;
        rd_q    <= read;
        wr_q    <= write;
        oow_q   <= oow_in;
      end
      if (mem_re) begin
        read_data <= mem[acc_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
          cnt_d   = CntInit;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    ready = (state_q == StResp);
    busy  = (state_q != StIdle);
`ifdef BUS_MEM_SLAVE_ERR_EN
    err   = (state_q == StResp) && (oow_q || (rd_q == wr_q));
`endif
  end

endmodule

// File: doc/bus_mem_slave.md
Name: bus_mem_slave

Overview:
Memory-backed slave target on the shared bus. It sits directly downstream of the master/decode stage. It decodes its own address window, accepts one read or write per handshake, and inserts a programmable number of wait states. It then performs the access and pulses ready with read data back to the master side of the bus.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 32, bus data width
MEM_DEPTH, 256, number of DATA_W words in local storage (power of 2, ≤ 4096)
WAIT_CYCLES, 2, wait states inserted between accept and response (0..15)
BASE_NIBBLE, 4'h0, value of addr[15:12] that selects this slave

Ports:
clk  input  1  bus clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
valid  input  1  master request valid; held until ready seen
read  input  1  read request qualifier
write  input  1  write request qualifier
addr  input  ADDR_W  byte-agnostic word address
write_data  input  DATA_W  write payload
ready  output  1  one-cycle completion pulse
read_data  output  DATA_W  read result, valid when ready && captured op was read
busy  output  1  high while a transaction is in flight (state != IDLE)

Behaviour:
- Reset (rst high at a rising edge): state=IDLE, ready=0, read_data=0, busy=0, wait counter=0. Memory contents are not reset.
- sel = valid && (addr[15:12] == BASE_NIBBLE). Index = addr[$clog2(MEM_DEPTH)-1:0]. addr[11:$clog2(MEM_DEPTH)] is ignored, so accesses alias.
- FSM states: IDLE, WAIT, RESP.
- IDLE: if sel at edge E0, capture addr index, write_data, read and write into internal registers.
  - WAIT_CYCLES>0: go to WAIT with cnt=WAIT_CYCLES-1.
  - WAIT_CYCLES=0: go directly to RESP.
  - Access for the WAIT_CYCLES=0 case is performed on E0.
- WAIT: cnt decrements each edge. On the edge where cnt==0, go to RESP and perform the access on that same edge.
- Access:
  - Captured write only: mem[index] <= captured write_data.
  - Captured read only: read_data <= mem[index].
  - Both read and write, or neither: illegal. No memory change, read_data unchanged.
- RESP: ready=1 for exactly this one cycle, then go to IDLE unconditionally. Inputs are ignored in RESP.
- Latency: ready is high in cycle WAIT_CYCLES+1 after the accept edge E0. Maximum throughput is one transaction per WAIT_CYCLES+2 cycles.
- Input changes after capture (addr, data, read, write) have no effect on the in-flight transaction.
- read_data holds its value until the next completed read.
- Deasserting valid during WAIT does not abort the transaction; it completes normally.
- Non-selected addresses in IDLE: no state change, ready stays 0.
- Reset mid-transaction: returns to IDLE, pending write is discarded, and ready is never pulsed.

Optional Feature:
- Macro: BUS_MEM_SLAVE_ERR_EN.
- When defined: adds output port err (1 bit), reset value 0. err is asserted together with ready in RESP in two cases:
  - the captured op is illegal (read && write, or neither);
  - addr[11:0] >= MEM_DEPTH (out of window).
  - Out-of-window accesses perform no memory change and leave read_data unchanged.
- When undefined: no err port. Illegal ops complete silently as described above, and out-of-window addresses alias.

Test Plan:
- Write 0xDEADBEEF to addr 0x0010, WAIT_CYCLES=2 -> ready high exactly 3 cycles after accept edge, 1 cycle wide; busy high for the 3 cycles after accept.
- Read addr 0x0010 after the previous write -> read_data=0xDEADBEEF in the ready cycle and held afterwards.
- valid with addr 0x1010 (addr[15:12]=1) -> ready never asserts, busy stays 0, mem[0x10] unchanged.
- WAIT_CYCLES=0: back-to-back writes to 0x0001 and 0x0002, valid held until ready -> each ready arrives 1 cycle after its accept, min spacing 2 cycles; readback returns both values.
- rst pulsed during WAIT of a write of 0x12345678 to 0x0020 -> no ready pulse; subsequent read of 0x0020 returns the old value.
- With BUS_MEM_SLAVE_ERR_EN: read=write=1 at 0x0005 -> ready and err both high for one cycle, memory unchanged. addr 0x0100 (MEM_DEPTH=256) -> err=1, read_data unchanged.
